// File: rtl/protocol_resp_tx.sv
// Response-packet transmitter: latches one response per handshake and streams
// HEADER, status, address, command, payload (MSB byte first), FOOTER over a valid/ready byte link.
module protocol_resp_tx #(
    parameter logic [7:0] HEADER     = 8'hFF,
    parameter logic [7:0] FOOTER     = 8'h7F,
    parameter int         DATA_BYTES = 3,
    localparam int        DW         = 8 * DATA_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [7:0]    status,
    input  logic [7:0]    sensor_addr,
    input  logic [7:0]    command,
    input  logic [DW-1:0] data,
    input  logic          abort,
    output logic [7:0]    out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        STAT = 3'd2,
        ADDR = 3'd3,
        CMD  = 3'd4,
        DATA = 3'd5,
        FTR  = 3'd6
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(DATA_BYTES - 1);

    state_t        state_r, state_next_s;
    logic [1:0]    cnt_r, cnt_next_s;
    logic [7:0]    status_r, addr_r, cmd_r;
    logic [DW-1:0] data_r;
    logic [7:0]    out_next_s;
    logic          accept_s, beat_s;

    // Payload byte idx counts from the most significant byte downwards.
    function automatic logic [7:0] data_byte(input logic [DW-1:0] d, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < DATA_BYTES; i++) begin
            b = (idx == 2'(DATA_BYTES - 1 - i)) ? d[8*i +: 8] : b;
        end
        return b;
    endfunction

    assign req_ready = (state_r == IDLE) && !abort;
    assign accept_s  = req_valid && req_ready;
    assign beat_s    = out_valid && out_ready;

    // Next-state and byte-counter logic; abort wins over any beat.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (abort) begin
            state_next_s = IDLE;
            cnt_next_s   = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) state_next_s = HDR;
                    else          state_next_s = IDLE;
                end
                HDR:  if (beat_s) state_next_s = STAT; else state_next_s = HDR;
                STAT: if (beat_s) state_next_s = ADDR; else state_next_s = STAT;
                ADDR: if (beat_s) state_next_s = CMD;  else state_next_s = ADDR;
                CMD: begin
                    if (beat_s) begin
                        state_next_s = DATA;
                        cnt_next_s   = 2'd0;
                    end else begin
                        state_next_s = CMD;
                    end
                end
                DATA: begin
                    if (beat_s && (cnt_r == CNT_LAST)) begin
                        state_next_s = FTR;
                        cnt_next_s   = 2'd0;
                    end else if (beat_s) begin
                        cnt_next_s   = cnt_r + 2'd1;
                    end else begin
                        cnt_next_s   = cnt_r;
                    end
                end
                FTR:  if (beat_s) state_next_s = IDLE; else state_next_s = FTR;
                default: begin
                    state_next_s = IDLE;
                    cnt_next_s   = 2'd0;
                end
            endcase
        end
    end

    // Byte presented in the next state, so out can be registered alongside the state.
    always_comb begin
        out_next_s = 8'h00;
        case (state_next_s)
            IDLE:    out_next_s = 8'h00;
            HDR:     out_next_s = HEADER;
            STAT:    out_next_s = status_r;
            ADDR:    out_next_s = addr_r;
            CMD:     out_next_s = cmd_r;
            DATA:    out_next_s = data_byte(data_r, cnt_next_s);
            FTR:     out_next_s = FOOTER;
            default: out_next_s = 8'h00;
        endcase
    end

    // Response field capture; abort discards the packet in flight.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            status_r <= 8'h00;
            addr_r   <= 8'h00;
            cmd_r    <= 8'h00;
            data_r   <= '0;
        end else if (accept_s) begin
            status_r <= status;
            addr_r   <= sensor_addr;
            cmd_r    <= command;
            data_r   <= data;
        end else begin
            status_r <= status_r;
            addr_r   <= addr_r;
            cmd_r    <= cmd_r;
            data_r   <= data_r;
        end
    end

    // State register and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 2'd0;
            out       <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            out       <= out_next_s;
            out_valid <= (state_next_s != IDLE);
            busy      <= (state_next_s != IDLE);
            done      <= (state_r == FTR) && beat_s && !abort;
        end
    end

endmodule

// File: tb/tb_protocol_resp_tx.sv
// Randomised bench for protocol_resp_tx: three instances (3, 1 and 4 payload bytes) share stimulus,
// each checked against a byte-queue model of the packet it should be sending.
module tb_protocol_resp_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  status = 8'h00;
    logic [7:0]  sensor_addr = 8'h00;
    logic [7:0]  command = 8'h00;
    logic [31:0] data = 32'h0;
    logic        chk_en = 1'b0;

    logic [7:0]  out_w [3];
    logic        req_ready_w [3];
    logic        out_valid_w [3];
    logic        busy_w [3];
    logic        done_w [3];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  obs0 [$];
    logic [7:0]  t1_exp [8] = '{8'hFF, 8'h01, 8'h0A, 8'h03, 8'h12, 8'h34, 8'h56, 8'h7F};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DB = (g == 0) ? 3 : ((g == 1) ? 1 : 4);

        protocol_resp_tx #(.HEADER(8'hFF), .FOOTER(8'h7F), .DATA_BYTES(DB)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid),
            .req_ready  (req_ready_w[g]),
            .status     (status),
            .sensor_addr(sensor_addr),
            .command    (command),
            .data       (data[8*DB-1:0]),
            .abort      (abort),
            .out        (out_w[g]),
            .out_valid  (out_valid_w[g]),
            .out_ready  (out_ready),
            .busy       (busy_w[g]),
            .done       (done_w[g])
        );

        // Model: bytes still owed to the sink; packet in flight whenever non-empty.
        logic [7:0] q [$];
        bit         done_exp = 1'b0;
        bit         in_flight;

        always @(negedge clk) begin
            if (chk_en) begin
                check_eq($sformatf("db%0d_req_ready", DB), 32'(req_ready_w[g]), 32'((q.size() == 0) && !abort));
                check_eq($sformatf("db%0d_out_valid", DB), 32'(out_valid_w[g]), 32'(q.size() != 0));
                check_eq($sformatf("db%0d_out", DB), 32'(out_w[g]), 32'((q.size() != 0) ? q[0] : 8'h00));
                check_eq($sformatf("db%0d_busy", DB), 32'(busy_w[g]), 32'(q.size() != 0));
                check_eq($sformatf("db%0d_done", DB), 32'(done_w[g]), 32'(done_exp));
                in_flight = (q.size() != 0);
                done_exp  = 1'b0;
                if (reset) begin
                    q.delete();
                end else begin
                    if (in_flight && out_ready) begin
                        void'(q.pop_front());
                        if ((q.size() == 0) && !abort) done_exp = 1'b1;
                    end
                    if (abort) begin
                        q.delete();
                    end else if (!in_flight && req_valid) begin
                        q.push_back(8'hFF);
                        q.push_back(status);
                        q.push_back(sensor_addr);
                        q.push_back(command);
                        for (int i = DB - 1; i >= 0; i--) q.push_back(data[8*i +: 8]);
                        q.push_back(8'h7F);
                    end
                end
            end
        end
    end

    // Byte log of the 3-byte instance for the literal packet checks.
    always @(negedge clk) begin
        if (chk_en && !reset && out_valid_w[0] && out_ready) obs0.push_back(out_w[0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_t1_bytes(input string tag);
        check_eq({tag, "_len"}, 32'(obs0.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s_b%0d", tag, i), 32'((i < obs0.size()) ? obs0[i] : 8'hXX), 32'(t1_exp[i]));
        end
    endtask

    task automatic send(input logic [7:0] st, input logic [7:0] ad, input logic [7:0] cm, input logic [31:0] d);
        status = st; sensor_addr = ad; command = cm; data = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Basic packet with the sink always ready
        obs0.delete();
        send(8'h01, 8'h0A, 8'h03, 32'h00123456);
        repeat (10) tick();
        check_t1_bytes("t1");

        // Same packet under 1,0,0,1 backpressure
        obs0.delete();
        send(8'h01, 8'h0A, 8'h03, 32'h00123456);
        for (int i = 0; i < 28; i++) begin
            out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
        end
        out_ready = 1'b1;
        repeat (8) tick();
        check_t1_bytes("t2");

        // Abort while the second payload byte is on the link, then a fresh packet
        send(8'h01, 8'h0A, 8'h03, 32'h00123456);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        send(8'h22, 8'h33, 8'h44, 32'h55667788);
        repeat (10) tick();

        // Back-to-back requests; fields change every cycle after accept
        req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            status = 8'($urandom); sensor_addr = 8'($urandom);
            command = 8'($urandom); data = $urandom;
            tick();
        end
        req_valid = 1'b0;
        repeat (10) tick();

        // Reset during the command byte, then a fresh packet
        send(8'h01, 8'h0A, 8'h03, 32'h00123456);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send(8'hFF, 8'h7F, 8'hFF, 32'hDEADBEEF);
        repeat (12) tick();

        // Random traffic: stalls, aborts, rare resets
        for (int i = 0; i < 4000; i++) begin
            req_valid   = ($urandom_range(0, 2) != 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            abort       = ($urandom_range(0, 39) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            status      = 8'($urandom);
            sensor_addr = 8'($urandom);
            command     = 8'($urandom);
            data        = $urandom;
            tick();
        end
        req_valid = 1'b0; abort = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (12) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
